// File: rtl/mem_access_fsm.sv
// Single-request access controller for a 2**ADDR_W x DATA_W word array. It holds the
// array strobe for WAIT_CYC+1 cycles, then reports completion until the consumer acks it.
module mem_access_fsm #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int WAIT_CYC = 1
) (
    input  logic              clkPE,
    input  logic              rstN,
    input  logic              sel,
    input  logic              op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ack,
    output logic              ready,
    output logic              valid,
    output logic              rw,
    output logic [DATA_W-1:0] rdata,
    output logic              drop,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    output logic              memWe,
    output logic              memRe,
    input  logic [DATA_W-1:0] memRdata,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a request is taken on an edge where sel=1 and ready=1; a sel seen while
    // ready=0 is discarded and flagged on drop for one cycle. A completion stays offered
    // (valid=1, rdata stable) until the edge where ack=1; ack at any other time is ignored.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [3:0] L_WAIT = 4'(WAIT_CYC);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_op;
    logic [DATA_W-1:0] r_rdata;
    logic              r_drop;

    always_ff @(posedge clkPE or negedge rstN) begin
        if (!rstN) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= 1'b0;
            r_rdata <= '0;
            r_drop  <= 1'b0;
        end else begin
            // Any request arriving outside IDLE is lost, including one coinciding with ack.
            r_drop <= sel && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (sel) begin
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_op    <= op;
                        r_cnt   <= L_WAIT;
                        r_state <= op ? S_WR : S_RD;
                    end
                end
                S_WR: begin
                    if (r_cnt == 4'd0) r_state <= S_RESP;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                S_RD: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                        r_rdata <= memRdata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (ack) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready       = (r_state == S_IDLE);
    assign valid       = (r_state == S_RESP);
    assign memWe       = (r_state == S_WR);
    assign memRe       = (r_state == S_RD);
    assign rw          = r_op && (r_state != S_IDLE);
    assign rdata       = r_rdata;
    assign drop        = r_drop;
    assign memAddr     = r_addr;
    assign memWdata    = r_wdata;
    assign o_dbg_state = r_state;

endmodule
